// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampling UART receiver, 1 start, DATA_BITS data, 1 stop.
// Received bytes leave on a valid/ready handshake; framing/overrun pulse.
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_enb,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_busy,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int TW = $clog2(OVERSAMPLE) + 1;
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [TW-1:0] HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  logic [1:0]           r_sync;
  state_t               r_state;
  logic [TW-1:0]        r_tick_cnt;
  logic [BW-1:0]        r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_busy;
  logic                 r_ferr;
  logic                 r_ovr;

  logic w_rx_s;
  logic w_accept;

  assign w_rx_s   = r_sync[1];
  assign w_accept = r_valid & rx_ready;

  assign rx_data   = r_data;
  assign rx_valid  = r_valid;
  assign rx_busy   = r_busy;
  assign frame_err = r_ferr;
  assign overrun   = r_ovr;

  // Two-flop synchronizer for the asynchronous serial line, idle high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], rx};
    end
  end

  // Frame FSM on oversample ticks plus the every-cycle output handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
      r_ferr     <= 1'b0;
      r_ovr      <= 1'b0;
    end else begin
      r_ferr <= 1'b0;
      r_ovr  <= 1'b0;
      if (w_accept) begin
        r_valid <= 1'b0;
      end
      if (rx_enb) begin
        unique case (r_state)
          S_IDLE: begin
            if (!w_rx_s) begin
              r_state    <= S_START;
              r_tick_cnt <= '0;
              r_busy     <= 1'b1;
            end
          end
          S_START: begin
            if (r_tick_cnt == HALF) begin
              r_tick_cnt <= '0;
              r_bit_cnt  <= '0;
              if (!w_rx_s) begin
                r_state <= S_DATA;
              end else begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + 1'b1;
            end
          end
          S_DATA: begin
            if (r_tick_cnt == FULL) begin
              r_tick_cnt <= '0;
              r_shift    <= {w_rx_s, r_shift[DATA_BITS-1:1]};
              if (r_bit_cnt == LAST) begin
                r_state <= S_STOP;
              end else begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + 1'b1;
            end
          end
          S_STOP: begin
            if (r_tick_cnt == FULL) begin
              r_tick_cnt <= '0;
              if (w_rx_s) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
                r_data  <= r_shift;
                r_valid <= 1'b1;
                r_ovr   <= r_valid & ~rx_ready;
              end else begin
                r_state <= S_BREAK;
                r_ferr  <= 1'b1;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + 1'b1;
            end
          end
          S_BREAK: begin
            if (w_rx_s) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

16x-oversampling UART receiver that consumes the `rx_enb` tick from the baud rate generator and turns the serial `rx` line into parallel bytes. Frame format is 1 start bit, DATA_BITS data bits (LSB first), 1 stop bit, no parity. Received bytes are presented on a valid/ready handshake to the downstream consumer. Framing errors and overruns are flagged.

## Interface

- DATA_BITS, 8, data bits per frame (5–9 legal)
- OVERSAMPLE, 16, `rx_enb` ticks per bit period (even, ≥4)

- clk  in  1  system clock; the only clock
- rst  in  1  reset, asynchronous, active-low
- rx_enb  in  1  oversample tick, one-cycle pulse, OVERSAMPLE per bit
- rx  in  1  serial line, asynchronous to clk, idle high
- rx_data  out  DATA_BITS  received byte, valid while rx_valid=1
- rx_valid  out  1  byte available; held until accepted
- rx_ready  in  1  consumer accepts byte when rx_valid&rx_ready
- rx_busy  out  1  high in any state other than IDLE
- frame_err  out  1  one-cycle pulse: stop bit sampled low
- overrun  out  1  one-cycle pulse: new byte completed while rx_valid still high

## Operation

- `rx` passes through a 2-flop synchronizer (flops reset to 1); all logic below uses the synchronized value `rx_s`.
- The FSM, tick counter and bit counter advance only on cycles with rx_enb=1. The output handshake runs every cycle.
- States:
  - IDLE: on a tick with rx_s=0, go to START and set tick_cnt=0.
  - START: on each tick, tick_cnt++. At the tick where tick_cnt reaches OVERSAMPLE/2 (the 8th tick after detection):
    - rx_s=0: go to DATA with tick_cnt=0, bit_cnt=0.
    - rx_s=1: glitch; go to IDLE with no flag.
  - DATA: on each tick, tick_cnt++. At the tick where tick_cnt reaches OVERSAMPLE, sample rx_s into shift[bit_cnt] (LSB first) and reset tick_cnt to 0. After bit DATA_BITS-1, go to STOP; otherwise bit_cnt++.
  - STOP: at the OVERSAMPLE-th tick, sample rx_s.
    - rx_s=1: load rx_data, then go to IDLE.
    - rx_s=0: pulse frame_err, discard the byte, go to BREAK.
  - BREAK: stay until a tick with rx_s=1, then go to IDLE. This prevents repeated errors on a held-low line.
- Output handshake:
  - A good stop bit sets rx_valid=1 and loads rx_data.
  - rx_valid clears on the cycle after rx_valid&rx_ready.
  - If a good stop bit occurs while rx_valid=1 and it is not being accepted that same cycle: pulse overrun, overwrite rx_data with the new byte, keep rx_valid=1.
  - If acceptance and a new byte land on the same cycle: the new byte loads, rx_valid stays 1, no overrun.
- rx_data is stable whenever rx_valid=1, except on an overrun overwrite.

## Timing

- Reset values:
  - rx_data=0, rx_valid=0, rx_busy=0, frame_err=0, overrun=0
  - FSM=IDLE, tick_cnt=0, bit_cnt=0, synchronizer=11
- Reset assertion mid-frame aborts the frame immediately and asynchronously. No flag is raised.
- Latency from `rx` pin to rx_s is 2 clk.
- rx_valid and overrun/frame_err rise on the clk edge after the stop-bit sampling tick (registered outputs).
- Detection tick plus OVERSAMPLE/2 + (DATA_BITS+1)·OVERSAMPLE ticks to the stop sample; 152 ticks for the defaults.
- rx_busy rises the cycle after the detection tick. It falls the cycle after the stop sample, or after exit from BREAK.
- A new start bit can be detected on the first tick after returning to IDLE. This allows back-to-back frames with no idle gap.
- tick_cnt width is clog2(OVERSAMPLE)+1, and it never wraps. bit_cnt width is clog2(DATA_BITS).
- If rx_enb is held high every cycle, the block must still operate correctly (1 tick per clk).

## Test plan

- rx_enb every clk; drive 0xA5 frame (16 clk/bit), rx_ready=1: rx_valid pulses 1 cycle with rx_data=0xA5, frame_err=0, rx_busy low after the stop sample.
- Low glitch of 5 ticks on idle line: no rx_valid, FSM returns to IDLE, rx_busy high only during the glitch window.
- Frame 0x3C with stop bit low, line high 2 bit times later: frame_err 1-cycle pulse, rx_valid stays 0, BREAK exits on the first high tick, next frame 0x81 received correctly.
- rx_ready=0; send 0x11 then 0x22 back-to-back: rx_valid high from the first byte, overrun pulses at the second stop, rx_data=0x22; raise rx_ready: rx_valid drops the next cycle.
- rx_enb one clk in 4, frames 0x00 and 0xFF with no idle gap: both bytes received, no errors.
- Assert rst during bit 4 of 0x5A, release, then send 0xC3: all outputs at reset values while in reset; only 0xC3 is delivered.
